// File: rtl/spi_trace_pkg.sv
// Shared types and helpers for the SPI trace capture engine.
package spi_trace_pkg;

  localparam int DEFAULT_PROBE_W = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4,
    READ  = 3'd5
  } trace_state_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_trace_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The array has no reset; the read register holds its value while re is low.
module trace_ram
  import spi_trace_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_trace_capture.sv
// Trigger-based trace buffer with pre-trigger window and in-order readout.
// Optional macro TRACE_TIMESTAMP_EN prepends a TS_W-bit timestamp to each word.
module spi_trace_capture
  import spi_trace_pkg::*;
#(
  parameter int PROBE_W  = DEFAULT_PROBE_W,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256,
  parameter int TS_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROBE_W-1:0] probe_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic [PROBE_W-1:0] trig_value_i,
  input  logic [PROBE_W-1:0] trig_mask_i,
  output logic [2:0]         state_o,
  output logic               triggered_o,
  output logic               done_o,
  input  logic               rd_ready_i,
  output logic               rd_valid_o,
`ifdef TRACE_TIMESTAMP_EN
  output logic [PROBE_W+TS_W-1:0] rd_data_o,
`else
  output logic [PROBE_W-1:0]      rd_data_o,
`endif
  output logic               rd_last_o
);

  localparam int AW     = addr_w(DEPTH);
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = PROBE_W + TS_W;
`else
  localparam int DW = PROBE_W;
`endif
  localparam logic [AW-1:0] FILL_LAST = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   ALL_READ  = (AW+1)'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PRE_TRIG < 0 ||
      PRE_TRIG >= DEPTH || PROBE_W < 1 || TS_W < 1) begin : g_bad_cfg
    $error("spi_trace_capture: illegal parameter combination");
  end

  trace_state_t      state, state_d;
  logic [PROBE_W-1:0] probe_q;
  logic              match, match_prev, fire;
  logic [AW-1:0]     wr_ptr, cnt, trig_addr, rd_ptr, out_cnt;
  logic [AW:0]       issue_cnt;
  logic              ram_vld, triggered_q;
  logic              we, re, xfer, rd_last;
  logic [DW-1:0]     wdata, rdata;

  assign match = ((probe_q ^ trig_value_i) & trig_mask_i) == '0;
  assign fire  = (state == ARMED) & match & (~match_prev | (trig_mask_i == '0));

  // Read port: a word is transferred on rd_valid_o & rd_ready_i; while valid
  // is high and ready is low, data and last are held because the RAM read
  // register is only reloaded when the current word is consumed (or empty).
  assign xfer    = ram_vld & rd_ready_i;
  assign rd_last = ram_vld & (out_cnt == LAST_IDX);
  assign we      = ~abort_i & (state inside {FILL, ARMED, POST});
  assign re      = ~abort_i & (state == READ) & (issue_cnt != ALL_READ) &
                   (~ram_vld | rd_ready_i);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (arm_i) state_d = (PRE_TRIG == 0) ? ARMED : FILL;
      FILL:    if (cnt == FILL_LAST) state_d = ARMED;
      ARMED:   if (fire) state_d = (POST_N == 0) ? DONE : POST;
      POST:    if (cnt == POST_LAST) state_d = DONE;
      DONE:    state_d = READ;
      READ:    if (xfer && rd_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      probe_q     <= '0;
      match_prev  <= 1'b0;
      wr_ptr      <= '0;
      cnt         <= '0;
      trig_addr   <= '0;
      rd_ptr      <= '0;
      issue_cnt   <= '0;
      out_cnt     <= '0;
      ram_vld     <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state      <= state_d;
      probe_q    <= probe_i;
      match_prev <= match;
      if (abort_i) begin
        wr_ptr      <= '0;
        cnt         <= '0;
        trig_addr   <= '0;
        rd_ptr      <= '0;
        issue_cnt   <= '0;
        out_cnt     <= '0;
        ram_vld     <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        case (state)
          IDLE: if (arm_i) begin
            wr_ptr      <= '0;
            cnt         <= '0;
            triggered_q <= 1'b0;
          end
          FILL: begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= (cnt == FILL_LAST) ? '0 : cnt + 1'b1;
          end
          ARMED: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fire) begin
              trig_addr   <= wr_ptr;
              triggered_q <= 1'b1;
              cnt         <= '0;
            end
          end
          POST: begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= cnt + 1'b1;
          end
          DONE: begin
            // Oldest kept sample sits PRE_TRIG slots behind the trigger.
            rd_ptr    <= trig_addr - PRE_OFS;
            issue_cnt <= '0;
            out_cnt   <= '0;
          end
          READ: begin
            if (re) begin
              rd_ptr    <= rd_ptr + 1'b1;
              issue_cnt <= issue_cnt + 1'b1;
            end
            if (re) ram_vld <= 1'b1;
            else if (xfer) ram_vld <= 1'b0;
            if (xfer) out_cnt <= out_cnt + 1'b1;
            if (xfer && rd_last) triggered_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk) begin
    if (!rst_n) ts <= '0;
    else if (state == IDLE && arm_i) ts <= '0;
    else ts <= ts + 1'b1;
  end
  assign wdata = {ts, probe_q};
`else
  assign wdata = probe_q;
`endif

  trace_ram #(.W(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (re),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign state_o     = state;
  assign triggered_o = triggered_q;
  assign done_o      = (state == DONE) | (state == READ);
  assign rd_valid_o  = ram_vld;
  assign rd_data_o   = ram_vld ? rdata : '0;
  assign rd_last_o   = rd_last;

endmodule

// File: tb/tb_spi_trace_capture.sv
// Directed bench for spi_trace_capture: DEPTH=16 with PRE_TRIG=4 and PRE_TRIG=0.
module tb_spi_trace_capture;
  import spi_trace_pkg::*;

  localparam int PW    = 20;
  localparam int DEPTH = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RDW = PW + 16;
`else
  localparam int RDW = PW;
`endif

  typedef struct {
    bit          use_p0;
    logic [19:0] value;
    logic [19:0] mask;
    int          jump_after;
    logic [19:0] jump_to;
    logic [19:0] exp_start;
    logic [19:0] exp_trig;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0] probe = '0, trig_value = '0, trig_mask = '0;
  logic arm = 1'b0, abort = 1'b0, ready = 1'b0, sel = 1'b0;

  logic [2:0]     state_4, state_0;
  logic           trig_4, trig_0, done_4, done_0, valid_4, valid_0, last_4, last_0;
  logic [RDW-1:0] data_4, data_0;

  spi_trace_capture #(.PROBE_W(PW), .DEPTH(DEPTH), .PRE_TRIG(4), .TS_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .probe_i(probe), .arm_i(arm & ~sel), .abort_i(abort & ~sel),
    .trig_value_i(trig_value), .trig_mask_i(trig_mask), .state_o(state_4),
    .triggered_o(trig_4), .done_o(done_4), .rd_ready_i(ready & ~sel),
    .rd_valid_o(valid_4), .rd_data_o(data_4), .rd_last_o(last_4)
  );

  spi_trace_capture #(.PROBE_W(PW), .DEPTH(DEPTH), .PRE_TRIG(0), .TS_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .probe_i(probe), .arm_i(arm & sel), .abort_i(abort & sel),
    .trig_value_i(trig_value), .trig_mask_i(trig_mask), .state_o(state_0),
    .triggered_o(trig_0), .done_o(done_0), .rd_ready_i(ready & sel),
    .rd_valid_o(valid_0), .rd_data_o(data_0), .rd_last_o(last_0)
  );

  logic [2:0]    m_state;
  logic          m_trig, m_done, m_valid, m_last;
  logic [PW-1:0] m_data;
  logic [RDW-1:0] m_data_full;
  assign m_state     = sel ? state_0 : state_4;
  assign m_trig      = sel ? trig_0 : trig_4;
  assign m_done      = sel ? done_0 : done_4;
  assign m_valid     = sel ? valid_0 : valid_4;
  assign m_last      = sel ? last_0 : last_4;
  assign m_data_full = sel ? data_0 : data_4;
  assign m_data      = m_data_full[PW-1:0];

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    probe = probe + 1'b1;
  endtask

  // Leaves probe_q == 0 on the edge that accepts arm, so FILL stores 1,2,3,...
  task automatic arm_capture();
    probe = '0;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!m_done && k < 300) begin
      tick();
      k++;
    end
    check("done_reached", m_done, 1);
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    int k;
    int pre;
    bit saw_fill;
    logic [PW-1:0] e;
    sel = v.use_p0;
    trig_value = v.value;
    trig_mask = v.mask;
    ready = 1'b0;
    pre = v.use_p0 ? 0 : 4;
    arm_capture();
    k = 0;
    saw_fill = 1'b0;
    while (!m_done && k < 300) begin
      if (m_state == FILL) saw_fill = 1'b1;
      tick();
      k++;
      if (v.jump_after > 0 && k == v.jump_after) begin
        check({tag, "_no_early_trig"}, m_trig, 0);
        probe = v.jump_to;
      end
    end
    check({tag, "_done"}, m_done, 1);
    check({tag, "_triggered"}, m_trig, 1);
    check({tag, "_fill_seen"}, saw_fill, !v.use_p0);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(v.exp_start + PW'(i));
    ready = 1'b1;
    tick();
    check({tag, "_valid_lat1"}, m_valid, 0);
    tick();
    check({tag, "_valid_lat2"}, m_valid, 1);
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, m_valid, 1);
      check({tag, "_data"}, m_data, e);
      check({tag, "_last"}, m_last, (i == DEPTH - 1));
      if (i == pre) check({tag, "_trig_word"}, m_data, v.exp_trig);
      tick();
    end
    check({tag, "_idle_after"}, m_state, IDLE);
    check({tag, "_done_clr"}, m_done, 0);
    check({tag, "_trig_clr"}, m_trig, 0);
    ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int stalls;
    logic [PW-1:0] e;

    vecs[0] = '{use_p0: 1'b0, value: 20'd10, mask: 20'hFFFFF, jump_after: 0,
                jump_to: 20'd0, exp_start: 20'd6, exp_trig: 20'd10};
    vecs[1] = '{use_p0: 1'b1, value: 20'd3, mask: 20'hFFFFF, jump_after: 0,
                jump_to: 20'd0, exp_start: 20'd3, exp_trig: 20'd3};
    vecs[2] = '{use_p0: 1'b0, value: 20'd2, mask: 20'hFFFFF, jump_after: 20,
                jump_to: 20'hFFFF0, exp_start: 20'hFFFFE, exp_trig: 20'd2};
    vecs[3] = '{use_p0: 1'b0, value: 20'h12345, mask: 20'h00000, jump_after: 0,
                jump_to: 20'd0, exp_start: 20'd1, exp_trig: 20'd5};

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("rst_state", m_state, IDLE);
      check("rst_trig", m_trig, 0);
      check("rst_done", m_done, 0);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_last", m_last, 0);
    end

    // Table-driven captures
    for (int i = 0; i < 4; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: 3 stalled cycles mid-stream
    sel = 1'b0;
    trig_value = 20'd10;
    trig_mask = 20'hFFFFF;
    ready = 1'b0;
    arm_capture();
    wait_done();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(20'd6 + PW'(i));
    k = 0;
    stalls = 0;
    while (exp_q.size() > 0 && k < 80) begin
      ready = !(k >= 8 && k < 11);
      if (m_valid) begin
        if (ready) begin
          e = exp_q.pop_front();
          check("stall_data", m_data, e);
          check("stall_last", m_last, (exp_q.size() == 0));
        end else begin
          stalls++;
          check("stall_hold", m_data, exp_q[0]);
        end
      end
      tick();
      k++;
    end
    check("stall_all_words", exp_q.size(), 0);
    check("stall_cycles", stalls, 3);
    check("stall_idle", m_state, IDLE);
    exp_q.delete();
    ready = 1'b0;

    // Abort during POST, then a fresh capture
    arm_capture();
    k = 0;
    while (m_state != POST && k < 100) begin
      tick();
      k++;
    end
    check("abort_reach_post", m_state, POST);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", m_state, IDLE);
    check("abort_trig", m_trig, 0);
    check("abort_done", m_done, 0);
    check("abort_valid", m_valid, 0);
    check("abort_data", m_data, 0);
    check("abort_last", m_last, 0);
    tick();
    check("abort_stays_idle", m_state, IDLE);
    run_vector(vecs[0], "rearm");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
